// File: rtl/lse_clut_pkg.sv
// Shared types, default LSE correction curve and interpolation arithmetic
// for the programmable correction LUT.
package lse_clut_pkg;

  typedef enum logic {INIT, RUN} clut_state_t;

  localparam logic [15:0] DEFAULT_CLUT [16] = '{
    16'h000, 16'h012, 16'h023, 16'h033, 16'h042, 16'h050, 16'h05D, 16'h069,
    16'h074, 16'h07E, 16'h087, 16'h08F, 16'h096, 16'h09C, 16'h0A1, 16'h0A5
  };

  // e0 + floor((e1 - e0) * frac / 2^frac_w); the result lies between e0 and e1.
  function automatic logic [31:0] interp_calc(input logic [31:0] e0,
                                              input logic [31:0] e1,
                                              input logic [7:0]  frac,
                                              input int          frac_w);
    logic signed [43:0] d;
    logic signed [43:0] f;
    logic signed [43:0] p;
    logic signed [43:0] s;
    d = $signed({12'd0, e1}) - $signed({12'd0, e0});
    f = $signed({36'd0, frac});
    p = d * f;
    s = $signed({12'd0, e0}) + (p >>> frac_w);
    if (frac == 8'd0) s = $signed({12'd0, e0});
    return 32'(s);
  endfunction

endpackage

// File: rtl/lse_clut_interp_ch.sv
// One read channel: S1 captures the two neighbouring entries and controls,
// S2 registers the (optionally interpolated) correction.
module lse_clut_interp_ch
  import lse_clut_pkg::*;
#(
  parameter int ENTRY_WIDTH = 10,
  parameter int FRAC_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_i,
  input  logic                   interp_en_i,
  input  logic [FRAC_W-1:0]      frac_i,
  input  logic [ENTRY_WIDTH-1:0] e0_i,
  input  logic [ENTRY_WIDTH-1:0] e1_i,
  output logic [ENTRY_WIDTH-1:0] correction_o,
  output logic                   valid_o
);

  logic                   vld_p1_q;
  logic                   ie_p1_q;
  logic [FRAC_W-1:0]      frac_p1_q;
  logic [ENTRY_WIDTH-1:0] e0_p1_q;
  logic [ENTRY_WIDTH-1:0] e1_p1_q;
  logic [ENTRY_WIDTH-1:0] corr_p2_d;
  logic [ENTRY_WIDTH-1:0] corr_p2_q;
  logic                   vld_p2_q;

  // S1
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_i;
  end

  always_ff @(posedge clk) begin
    if (vld_i) begin
      ie_p1_q   <= interp_en_i;
      frac_p1_q <= frac_i;
      e0_p1_q   <= e0_i;
      e1_p1_q   <= e1_i;
    end
  end

  always_comb begin
    corr_p2_d = e0_p1_q;
    if (ie_p1_q)
      corr_p2_d = ENTRY_WIDTH'(interp_calc(32'(e0_p1_q), 32'(e1_p1_q),
                                           8'(frac_p1_q), FRAC_W));
  end

  // S2
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      corr_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) corr_p2_q <= corr_p2_d;
    end
  end

  assign correction_o = corr_p2_q;
  assign valid_o      = vld_p2_q;

endmodule

// File: rtl/lse_clut_prog.sv
// Run-time programmable LSE correction LUT: register-file table filled with
// the default curve after reset, read by NUM_CH independent 2-cycle channels.
module lse_clut_prog
  import lse_clut_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int ENTRY_WIDTH = 10,
  parameter  int FRAC_W      = 4,
  parameter  int NUM_CH      = 2,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_we,
  input  logic [ADDR_W-1:0]                cfg_addr,
  input  logic [ENTRY_WIDTH-1:0]           cfg_data,
  output logic                             cfg_ready,
  output logic                             init_done,
  input  logic                             interp_en,
  input  logic [NUM_CH-1:0]                rd_valid_in,
  input  logic [NUM_CH*(ADDR_W+FRAC_W)-1:0] rd_addr,
  output logic [NUM_CH*ENTRY_WIDTH-1:0]    correction,
  output logic [NUM_CH-1:0]                valid_out
);

  localparam int RA_W = ADDR_W + FRAC_W;

  clut_state_t            state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [ENTRY_WIDTH-1:0] tbl_q [DEPTH];
  logic [3:0]             def_idx;
  logic [ENTRY_WIDTH-1:0] def_w;
  logic                   run_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + ADDR_W'(1);
      if (idx_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end
  end

  always_comb begin
    run_w     = (state_q == RUN);
    init_done = run_w;
    cfg_ready = run_w;
  end

  // The 16-point default curve is stretched or decimated to fill DEPTH entries.
  always_comb begin
    def_idx = 4'((int'(idx_q) * 16) / DEPTH);
    def_w   = ENTRY_WIDTH'(DEFAULT_CLUT[def_idx]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run_w)      tbl_q[idx_q]    <= def_w;
      else if (cfg_we) tbl_q[cfg_addr] <= cfg_data;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [RA_W-1:0]   ra;
    logic [ADDR_W-1:0] i0;
    logic [ADDR_W-1:0] i1;

    assign ra = rd_addr[c*RA_W +: RA_W];
    assign i0 = ra[RA_W-1:FRAC_W];
    // Top entry has no upper neighbour, so it interpolates against itself.
    assign i1 = (i0 == ADDR_W'(DEPTH - 1)) ? i0 : i0 + ADDR_W'(1);

    lse_clut_interp_ch #(
      .ENTRY_WIDTH(ENTRY_WIDTH),
      .FRAC_W     (FRAC_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .vld_i       (rd_valid_in[c] & run_w),
      .interp_en_i (interp_en),
      .frac_i      (ra[FRAC_W-1:0]),
      .e0_i        (tbl_q[i0]),
      .e1_i        (tbl_q[i1]),
      .correction_o(correction[c*ENTRY_WIDTH +: ENTRY_WIDTH]),
      .valid_o     (valid_out[c])
    );
  end

endmodule

// File: tb/tb_lse_clut_prog.sv
// Scoreboard bench for lse_clut_prog: directed cases from the test plan plus
// randomized traffic checked against an arithmetic table model.
module tb_lse_clut_prog;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [9:0]  cfg_data = '0;
  logic        cfg_ready;
  logic        init_done;
  logic        interp_en = 1'b0;
  logic [1:0]  rd_valid_in = '0;
  logic [15:0] rd_addr = '0;
  logic [19:0] correction;
  logic [1:0]  valid_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rst_seen = 1'b1;
  int   last_corr [2] = '{0, 0};
  int   rel_steps = 0;

  int DEF [16] = '{'h000, 'h012, 'h023, 'h033, 'h042, 'h050, 'h05D, 'h069,
                   'h074, 'h07E, 'h087, 'h08F, 'h096, 'h09C, 'h0A1, 'h0A5};
  int   mtab [16];
  exp_t q0 [$];
  exp_t q1 [$];

  bit rv [2];
  int ti [2];
  int tf [2];
  int ov [2];
  bit ie;
  bit we;
  int wa;
  int wd;

  lse_clut_prog #(
    .DEPTH(16), .ENTRY_WIDTH(10), .FRAC_W(4), .NUM_CH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .init_done  (init_done),
    .interp_en  (interp_en),
    .rd_valid_in(rd_valid_in),
    .rd_addr    (rd_addr),
    .correction (correction),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: linear blend of neighbouring entries, rounded toward minus infinity.
  function automatic int model(int i, int f, bit en);
    int e0, e1, n, q;
    e0 = mtab[i];
    e1 = (i == 15) ? e0 : mtab[i+1];
    if (!en || f == 0) return e0;
    n = (e1 - e0) * f;
    q = n / 16;
    if ((n % 16) != 0 && n < 0) q = q - 1;
    return (e0 + q) & 'h3FF;
  endfunction

  task automatic push_exp(int c, int v, int d);
    exp_t e;
    e.val = v;
    e.due = d;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle();
    for (int c = 0; c < 2; c++) begin
      rv[c] = 1'b0; ti[c] = 0; tf[c] = 0; ov[c] = -1;
    end
    ie = 1'b0; we = 1'b0; wa = 0; wd = 0;
  endtask

  task automatic req(int c, int i, int f, int exp_v);
    rv[c] = 1'b1; ti[c] = i; tf[c] = f; ov[c] = exp_v;
  endtask

  task automatic step();
    bit run;
    run = (rel_steps >= 16) && !rst;
    rd_valid_in = {rv[1], rv[0]};
    rd_addr     = {4'(ti[1]), 4'(tf[1]), 4'(ti[0]), 4'(tf[0])};
    interp_en   = ie;
    cfg_we      = we;
    cfg_addr    = 4'(wa);
    cfg_data    = 10'(wd);
    if (run) begin
      for (int c = 0; c < 2; c++)
        if (rv[c]) push_exp(c, (ov[c] >= 0) ? ov[c] : model(ti[c], tf[c], ie), cyc + 2);
      if (we) mtab[wa] = wd;
    end
    if (rst) begin
      while (q0.size() > 0 && q0[$].due > cyc) void'(q0.pop_back());
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
      for (int i = 0; i < 16; i++) mtab[i] = DEF[i];
    end
    @(posedge clk);
    #1;
    if (rst) rel_steps = 0;
    else     rel_steps++;
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic [9:0] act;
      exp_t       e;
      act = correction[c*10 +: 10];
      if (rst_seen) begin
        chk($sformatf("reset_valid_ch%0d", c), 32'(valid_out[c]), 32'd0);
        chk($sformatf("reset_corr_ch%0d", c), 32'(act), 32'd0);
        last_corr[c] = 0;
      end else if (valid_out[c]) begin
        if ((c == 0 ? q0.size() : q1.size()) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid_ch%0d: got valid_out=1 data %0h, required no result", c, act);
        end else begin
          if (c == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("corr_ch%0d", c), 32'(act), e.val);
          chk($sformatf("latency_ch%0d", c), cyc, e.due);
          last_corr[c] = int'(act);
        end
      end else begin
        chk($sformatf("hold_ch%0d", c), 32'(act), last_corr[c]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mtab[i] = DEF[i];
    idle();
    rst = 1'b1;
    repeat (3) step();
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_correction", 32'(correction), 32'd0);

    // Initial table load; a read and a write during INIT must be ignored.
    rst = 1'b0;
    while (rel_steps < 16) begin
      idle();
      if (rel_steps == 3) req(0, 3, 0, -1);
      if (rel_steps == 5) begin we = 1'b1; wa = 0; wd = 'h155; end
      step();
      chk($sformatf("init_done_k%0d", rel_steps), 32'(init_done), (rel_steps >= 16) ? 32'd1 : 32'd0);
    end
    chk("cfg_ready_run", 32'(cfg_ready), 32'd1);

    idle(); ie = 1'b1; req(0, 5, 0, 'h050); step();
    for (int i = 0; i < 16; i++) begin
      idle(); req(0, i, 0, DEF[i]); step();
    end

    idle(); ie = 1'b1; req(0, 2, 0, 'h023); req(1, 2, 8, 'h02B); step();
    idle(); req(0, 2, 0, 'h023); step();

    idle(); ie = 1'b1; req(0, 1, 8, 'h01A); step();
    idle(); ie = 1'b1; req(1, 15, 15, 'h0A5); step();
    idle(); ie = 1'b0; req(0, 1, 8, 'h012); step();

    idle(); we = 1'b1; wa = 3; wd = 'h3FF; req(0, 3, 0, 'h033); step();
    idle(); req(0, 3, 0, 'h3FF); step();
    idle(); we = 1'b1; wa = 4; wd = 0; step();
    idle(); ie = 1'b1; req(0, 3, 8, 'h1FF); req(1, 4, 0, 'h000); step();
    idle(); step(); step();

    repeat (400) begin
      idle();
      for (int c = 0; c < 2; c++)
        if ($urandom_range(3) != 0) req(c, int'($urandom_range(15)), int'($urandom_range(15)), -1);
      ie = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) begin
        we = 1'b1; wa = int'($urandom_range(15)); wd = int'($urandom_range(1023));
      end
      step();
    end

    // Reset with reads in flight; reprogrammed entry must revert after re-init.
    idle(); we = 1'b1; wa = 3; wd = 'h3FF; step();
    idle(); ie = 1'b1; req(0, 7, 5, -1); req(1, 3, 9, -1); step();
    idle(); req(0, 3, 0, -1); req(1, 3, 0, -1); step();
    rst = 1'b1;
    idle(); req(0, 3, 0, -1); step();
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_correction", 32'(correction), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    while (rel_steps < 16) begin
      idle(); req(1, 3, 0, -1); step();
      chk($sformatf("reinit_done_k%0d", rel_steps), 32'(init_done), (rel_steps >= 16) ? 32'd1 : 32'd0);
    end
    idle(); req(0, 3, 0, 'h033); req(1, 3, 0, 'h033); step();
    idle(); repeat (4) step();

    chk("queue_drain", q0.size() + q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
